// File: rtl/branch_control_unit.sv
// Fetch-and-steer controller: fetches at PcValue, decodes control-flow opcodes and steers the PC.
// Optional return-address stack for CALL/RET is compiled in with BCU_CALL_STACK_EN.
module branch_control_unit #(
  parameter int STACK_DEPTH = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [15:0]       PcValue,
  input  logic              ZeroFlag,
  output logic              InstrReq,
  output logic [15:0]       InstrAddr,
  input  logic              InstrReady,
  input  logic [15:0]       InstrData,
  output logic [15:0]       LoadValue,
  output logic              LoadEnable,
  output logic signed [8:0] Offset,
  output logic              OffsetEnable,
  output logic [15:0]       InstrOut,
  output logic              InstrValid,
  output logic              Halted,
  output logic              StackError
);

  typedef enum logic {
    FETCH,
    HALTED
  } state_t;

  state_t state, next_state;

  logic [3:0]  opcode;
  logic        is_halt;
  logic        forward;
  logic        push;
  logic        pop;
  logic        stack_fault;
  logic [15:0] return_addr;

  assign opcode      = InstrData[15:12];
  assign is_halt     = (InstrData == 16'hFFFF);
  assign return_addr = PcValue + 16'd1;
  assign InstrAddr   = PcValue;
  assign Halted      = (state == HALTED);

`ifdef BCU_CALL_STACK_EN
  localparam int PTR_W = $clog2(STACK_DEPTH);

  logic [15:0]    stack_mem [STACK_DEPTH];
  logic [PTR_W:0] stack_ptr;
  logic [PTR_W:0] top_ptr;
  logic           stack_full;
  logic           stack_empty;
  logic [15:0]    stack_top;

  assign stack_full  = (stack_ptr == (PTR_W + 1)'(STACK_DEPTH));
  assign stack_empty = (stack_ptr == '0);
  assign top_ptr     = stack_ptr - 1'b1;
  assign stack_top   = stack_mem[top_ptr[PTR_W-1:0]];

  // Push/pop only commit on an accepting edge; the decode qualifies them.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      stack_ptr <= '0;
    end else if (push) begin
      stack_mem[stack_ptr[PTR_W-1:0]] <= return_addr;
      stack_ptr <= stack_ptr + 1'b1;
    end else if (pop) begin
      stack_ptr <= top_ptr;
    end
  end
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= FETCH;
      InstrOut   <= 16'h0000;
      InstrValid <= 1'b0;
      StackError <= 1'b0;
    end else begin
      state      <= next_state;
      InstrValid <= forward;
      if (forward)
        InstrOut <= InstrData;
      if (stack_fault)
        StackError <= 1'b1;
    end
  end

  // Combinational PC steering; no register sits in the PC control loop.
  always_comb begin
    next_state   = state;
    InstrReq     = 1'b0;
    LoadEnable   = 1'b0;
    LoadValue    = PcValue;
    OffsetEnable = 1'b0;
    Offset       = '0;
    forward      = 1'b0;
    push         = 1'b0;
    pop          = 1'b0;
    stack_fault  = 1'b0;

    if (!Reset) begin
      unique case (state)
        FETCH: begin
          InstrReq = 1'b1;
          if (!InstrReady) begin
            LoadEnable = 1'b1;
          end else if (is_halt) begin
            LoadEnable = 1'b1;
            next_state = HALTED;
          end else begin
            case (opcode)
              4'hA: begin
                OffsetEnable = 1'b1;
                Offset       = InstrData[8:0];
              end
              4'hB: begin
                if (ZeroFlag) begin
                  OffsetEnable = 1'b1;
                  Offset       = InstrData[8:0];
                end else begin
                  forward = 1'b1;
                end
              end
              4'hC: begin
                LoadEnable = 1'b1;
                LoadValue  = {4'h0, InstrData[11:0]};
              end
`ifdef BCU_CALL_STACK_EN
              4'hD: begin
                LoadEnable = 1'b1;
                LoadValue  = {4'h0, InstrData[11:0]};
                if (stack_full)
                  stack_fault = 1'b1;
                else
                  push = 1'b1;
              end
              // An empty-stack RET lets the PC step on without forwarding.
              4'hE: begin
                if (stack_empty) begin
                  stack_fault = 1'b1;
                end else begin
                  LoadEnable = 1'b1;
                  LoadValue  = stack_top;
                  pop        = 1'b1;
                end
              end
`endif
              default: forward = 1'b1;
            endcase
          end
        end
        HALTED: begin
          LoadEnable = 1'b1;
        end
        default: next_state = FETCH;
      endcase
    end
  end

endmodule

// File: doc/branch_control_unit.md
# branch_control_unit

Fetch-and-steer controller that sits on the output side of the program counter. It takes the current PC value, fetches the instruction word from instruction memory with a ready handshake, and decodes control-flow opcodes. It then drives the PC's load, offset and hold controls, so the PC increments only when an ordinary instruction has been accepted. Non-control instructions are forwarded downstream with a one-cycle valid strobe.

## Interface
- STACK_DEPTH, 4, return-address stack entries; power of two, ≥2; only used with the call stack compiled in.

- Clock  in  1  system clock; all state updates on rising edge.
- Reset  in  1  reset, synchronous, active-high; clock Clock.
- PcValue  in  16  current PC value, driven from the program counter's CounterValue.
- ZeroFlag  in  1  datapath zero flag, sampled for conditional branch.
- InstrReq  out  1  instruction read request.
- InstrAddr  out  16  instruction address; always equals PcValue.
- InstrReady  in  1  memory has valid InstrData this cycle.
- InstrData  in  16  fetched instruction word.
- LoadValue  out  16  absolute PC target.
- LoadEnable  out  1  PC loads LoadValue next edge.
- Offset  out  signed 9  PC-relative displacement.
- OffsetEnable  out  1  PC adds Offset next edge.
- InstrOut  out  16  registered non-control instruction.
- InstrValid  out  1  one-cycle strobe qualifying InstrOut.
- Halted  out  1  HALT executed; sticky until Reset.
- StackError  out  1  sticky stack overflow/underflow flag.

## Operation
- Decode uses InstrData[15:12]:
  - 4'hA BR: unconditional relative branch; Offset = InstrData[8:0].
  - 4'hB BZ: relative branch taken only if ZeroFlag = 1; not taken behaves as an ordinary instruction.
  - 4'hC JMP: LoadValue = {4'h0, InstrData[11:0]}.
  - 4'hD CALL: push PcValue+1 (mod 2^16), then load as JMP.
  - 4'hE RET: pop stack into LoadValue.
  - 16'hFFFF HALT.
  - Anything else is ordinary.
- Offset is relative to the address of the branch instruction itself. The PC adds it to its current value, with wrap mod 2^16.
- Two states, FETCH and HALTED; Reset forces FETCH.
- FETCH, InstrReady = 0:
  - InstrReq = 1.
  - Hold the PC: LoadEnable = 1, LoadValue = PcValue.
- FETCH, InstrReady = 1, ordinary or untaken BZ:
  - LoadEnable = 0 and OffsetEnable = 0, so the PC increments.
  - InstrOut <= InstrData; InstrValid = 1 next cycle.
- FETCH, InstrReady = 1, control-flow opcode:
  - Assert the matching enable combinationally.
  - InstrValid = 0 next cycle; InstrOut is unchanged.
  - LoadEnable and OffsetEnable are never both 1.
- FETCH, HALT accepted: next state HALTED.
- HALTED:
  - InstrReq = 0, Halted = 1.
  - PC held through LoadEnable = 1, LoadValue = PcValue.
  - Exit only by Reset.
- Stack is a LIFO of STACK_DEPTH 16-bit entries with a pointer.
  - CALL when full: the jump executes, the push is dropped, StackError <= 1.
  - RET when empty: behaves as an ordinary instruction (PC increments, nothing forwarded), StackError <= 1.
- Reset cycle drives InstrReq = 0, LoadEnable = 0 and OffsetEnable = 0. The PC is being reset at the same edge.

## Timing
- Reset values: InstrValid 0, InstrOut 16'h0000, Halted 0, StackError 0, stack pointer 0 (empty), state FETCH.
- InstrReq, LoadEnable, LoadValue, Offset and OffsetEnable are combinational from state, InstrReady, InstrData, ZeroFlag and stack top. No registered path lies in the PC control loop.
- Throughput: one instruction per cycle while InstrReady is held at 1.
- The PC update takes effect at the edge where the instruction is accepted. The next FETCH cycle presents the new address.
- InstrValid/InstrOut latency: 1 cycle after the accepting edge.
- Stall cycles hold the PC indefinitely; no timeout.
- Reset asserted mid-fetch or in HALTED: the state machine is in FETCH after that edge, and any pending instruction is discarded.
- A stack push or pop commits on the accepting edge only.

## Configuration
- BCU_CALL_STACK_EN defined: CALL and RET behave as above, and the STACK_DEPTH stack is instantiated.
- BCU_CALL_STACK_EN undefined:
  - No stack storage.
  - 4'hD and 4'hE decode as ordinary instructions: forwarded, PC increments.
  - StackError tied 0.

## Test plan
- Reset, then ready held at 1 with ordinary words 16'h1234 and 16'h5678: PC goes 0→1→2; InstrValid pulses with InstrOut 16'h1234, then 16'h5678.
- Ready low for 3 cycles at PC = 5: InstrReq stays 1, LoadEnable = 1 with LoadValue 5, and PC remains 5. PC advances to 6 on the ready edge.
- BR 16'hA1FE at PC = 16'h0010: Offset = -2 and the next PC is 16'h000E. BZ 16'hB003 with ZeroFlag = 0 increments the PC and forwards the word.
- With the macro on and STACK_DEPTH = 4, CALL 16'hD100 at PC = 16'h0020: PC becomes 16'h0100. A subsequent RET loads 16'h0021. A 5th nested CALL sets StackError, and a RET on an empty stack also sets it.
- HALT at PC = 7: Halted = 1, InstrReq = 0, and the PC stays at 7 for 10 cycles. Reset clears Halted and the PC to 0.
